// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RISC-V controller
package riscv_ctrl_pkg;

  // Controller states; S_TRAP is only reachable when illegal-opcode trapping is built in
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_UPPER,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Immediate format selected purely from the opcode; loads, I-ALU and jalr share I
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:         imm_src = IMM_S;
      OP_BRANCH:        imm_src = IMM_B;
      OP_JAL:           imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:          imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp and instruction funct fields to an ALU operation
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control
);

  // Fixed add/sub for address and compare work, otherwise decode funct3/funct7
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM; MC_ILLEGAL_TRAP_EN adds illegal_o trap
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_LAT   = 0,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 ALUR31,
  input  logic                 branch_ltu,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic                 instr_done,
  output logic                 illegal_o
`else
  output logic                 instr_done
`endif
);

  state_t     state;
  state_t     out_state;
  logic       last_cnt;
  logic       is_legal;
  logic       taken;
  logic [1:0] alu_op;
  logic [3:0] alu_ctl;

  // Memory-facing states hold for MEM_LAT extra cycles; last_cnt marks the final one
  generate
    if (MEM_LAT == 0) begin : g_no_wait
      assign last_cnt = 1'b1;
    end else begin : g_wait
      localparam int CW = $clog2(MEM_LAT + 1);
      logic [CW-1:0] cnt;
      logic          mem_state;
      assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
      assign last_cnt  = (cnt == CW'(MEM_LAT));
      // Count up while a memory state is waiting, clear on the final count so exit leaves it at zero
      always_ff @(posedge clk) begin
        if (reset)
          cnt <= '0;
        else if (mem_state && !last_cnt)
          cnt <= cnt + CW'(1);
        else
          cnt <= '0;
      end
    end
  endgenerate

  // Opcodes the controller knows how to sequence
  always_comb begin
    is_legal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  end

  // Branch condition from the ALU compare flags; funct3 010/011 are never taken
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = ALUR31;
      3'b101:  taken = !ALUR31;
      3'b110:  taken = branch_ltu;
      3'b111:  taken = !branch_ltu;
      default: taken = 1'b0;
    endcase
  end

  // State sequencing; memory states advance only on their final wait count
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (last_cnt) state <= S_DECODE;
        S_DECODE: begin
          if (!is_legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
          end else begin
            case (op)
              OP_LOAD, OP_STORE: state <= S_MEMADR;
              OP_R:              state <= S_EXECR;
              OP_I:              state <= S_EXECI;
              OP_BRANCH:         state <= S_BRANCH;
              OP_JAL:            state <= S_JAL;
              OP_JALR:           state <= S_JALR;
              default:           state <= S_UPPER;
            endcase
          end
        end
        S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (last_cnt) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (last_cnt) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JALR:     state <= S_JAL;
        S_JAL:      state <= S_ALUWB;
        S_UPPER:    state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // During reset the datapath sees FETCH selects with every strobe held low
  assign out_state = reset ? S_FETCH : state;

  // Per-state datapath selects and strobes
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (out_state)
      S_FETCH: begin
        IRWrite   = last_cnt;
        PCWrite   = last_cnt;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
`ifndef MC_ILLEGAL_TRAP_EN
        instr_done = !is_legal;
`endif
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = last_cnt;
        instr_done = last_cnt;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        PCWrite    = taken;
        instr_done = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_UPPER: begin
        ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign ImmSrc     = imm_src(op);
  assign ALUControl = ALUCTRL_W'(alu_ctl);

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_o = (state == S_TRAP) && !reset;
`endif

  alu_decoder u_alu_decoder (
    .opb5        (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (alu_op),
    .alu_control (alu_ctl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller (MEM_LAT 0 and 2)
module tb_multicycle_controller;

  localparam int T_RST = 0, T_FW = 1, T_F = 2, T_D = 3, T_DNOP = 4, T_MA = 5, T_MR = 6;
  localparam int T_MWB = 7, T_MWW = 8, T_MW = 9, T_XR = 10, T_XI = 11, T_WB = 12;
  localparam int T_BR = 13, T_JALR = 14, T_JAL = 15, T_UP = 16, T_TRAP = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0, zero = 1'b0, alur31 = 1'b0, branch_ltu = 1'b0;

  logic       d0_pcw, d0_adr, d0_mw, d0_irw, d0_rw, d0_done;
  logic [1:0] d0_res, d0_a, d0_b;
  logic [2:0] d0_imm;
  logic [3:0] d0_alu;
  logic       d2_pcw, d2_adr, d2_mw, d2_irw, d2_rw, d2_done;
  logic [1:0] d2_res, d2_a, d2_b;
  logic [2:0] d2_imm;
  logic [3:0] d2_alu;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       d0_ill, d2_ill;
`endif

  multicycle_controller #(.MEM_LAT(0), .ALUCTRL_W(4)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .ALUR31(alur31), .branch_ltu(branch_ltu),
    .PCWrite(d0_pcw), .AdrSrc(d0_adr), .MemWrite(d0_mw), .IRWrite(d0_irw),
    .RegWrite(d0_rw), .ResultSrc(d0_res), .ALUSrcA(d0_a), .ALUSrcB(d0_b),
    .ImmSrc(d0_imm), .ALUControl(d0_alu),
`ifdef MC_ILLEGAL_TRAP_EN
    .instr_done(d0_done), .illegal_o(d0_ill)
`else
    .instr_done(d0_done)
`endif
  );

  multicycle_controller #(.MEM_LAT(2), .ALUCTRL_W(4)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .ALUR31(alur31), .branch_ltu(branch_ltu),
    .PCWrite(d2_pcw), .AdrSrc(d2_adr), .MemWrite(d2_mw), .IRWrite(d2_irw),
    .RegWrite(d2_rw), .ResultSrc(d2_res), .ALUSrcA(d2_a), .ALUSrcB(d2_b),
    .ImmSrc(d2_imm), .ALUControl(d2_alu),
`ifdef MC_ILLEGAL_TRAP_EN
    .instr_done(d2_done), .illegal_o(d2_ill)
`else
    .instr_done(d2_done)
`endif
  );

  logic [18:0] d0_vec, d2_vec;
  assign d0_vec = {d0_pcw, d0_adr, d0_mw, d0_irw, d0_rw, d0_res, d0_a, d0_b, d0_imm, d0_alu, d0_done};
  assign d2_vec = {d2_pcw, d2_adr, d2_mw, d2_irw, d2_rw, d2_res, d2_a, d2_b, d2_imm, d2_alu, d2_done};

  typedef struct {
    string       tag;
    int          sel;
    logic [18:0] exp;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  string       cur_name;
  int          cur_sel;
  logic [6:0]  cur_op;
  logic [3:0]  cur_aluc;
  logic        cur_tk;

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    case (o)
      7'b0100011:             imm_ref = 3'b001;
      7'b1100011:             imm_ref = 3'b010;
      7'b1101111:             imm_ref = 3'b011;
      7'b0110111, 7'b0010111: imm_ref = 3'b100;
      default:                imm_ref = 3'b000;
    endcase
  endfunction

  function automatic logic [18:0] ctl(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] res,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [3:0] alu, input logic done);
    ctl = {pcw, adr, mw, irw, rw, res, a, b, imm_ref(cur_op), alu, done};
  endfunction

  // Expected control word for each controller phase, taken from the state table
  function automatic logic [18:0] exp_of(input int s);
    case (s)
      T_RST, T_FW: exp_of = ctl(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 4'd0, 0);
      T_F:         exp_of = ctl(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 4'd0, 0);
      T_D:         exp_of = ctl(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 4'd0, 0);
      T_DNOP:      exp_of = ctl(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 4'd0, 1);
      T_MA:        exp_of = ctl(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0);
      T_MR:        exp_of = ctl(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0);
      T_MWB:       exp_of = ctl(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 4'd0, 1);
      T_MWW:       exp_of = ctl(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0);
      T_MW:        exp_of = ctl(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 1);
      T_XR:        exp_of = ctl(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, cur_aluc, 0);
      T_XI:        exp_of = ctl(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, cur_aluc, 0);
      T_WB:        exp_of = ctl(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 1);
      T_BR:        exp_of = ctl(cur_tk, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 4'd1, 1);
      T_JALR:      exp_of = ctl(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0);
      T_JAL:       exp_of = ctl(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'd0, 0);
      T_UP:        exp_of = ctl(0, 0, 0, 0, 0, 2'd0, cur_op[5] ? 2'd3 : 2'd1, 2'd1, 4'd0, 0);
      default:     exp_of = ctl(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0);
    endcase
  endfunction

  // Monitor: pop one expectation per cycle and compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, (e.sel == 1) ? {13'd0, d2_vec} : {13'd0, d0_vec}, {13'd0, e.exp});
    end
  end

  task automatic push_exp(input int s, input string t);
    exp_t e;
    e.tag = {cur_name, "/", t};
    e.sel = cur_sel;
    e.exp = exp_of(s);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input int s, input string t);
    @(posedge clk);
    #1;
    reset = rst;
    push_exp(s, t);
  endtask

  task automatic start(input string name, input int sel, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7, input logic z, input logic r,
                       input logic l, input logic [3:0] aluc, input logic tk);
    @(posedge clk);
    #1;
    cur_name = name; cur_sel = sel; cur_op = o; cur_aluc = aluc; cur_tk = tk;
    op = o; funct3 = f3; funct7b5 = f7; zero = z; alur31 = r; branch_ltu = l;
    reset = 1'b1;
    push_exp(T_RST, "rst");
  endtask

  task automatic branch_test(input string name, input logic [2:0] f3, input logic z,
                             input logic r, input logic l, input logic tk);
    start(name, 0, 7'b1100011, f3, 0, z, r, l, 4'd0, tk);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_BR, "BR"); cyc(0, T_F, "F2");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);

    start("add", 0, 7'b0110011, 3'b000, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_XR, "EXECR"); cyc(0, T_WB, "ALUWB"); cyc(0, T_F, "F2");

    start("sub", 0, 7'b0110011, 3'b000, 1, 0, 0, 0, 4'd1, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_XR, "EXECR"); cyc(0, T_WB, "ALUWB");

    start("srai", 0, 7'b0010011, 3'b101, 1, 0, 0, 0, 4'd9, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_XI, "EXECI"); cyc(0, T_WB, "ALUWB");

    start("sltiu", 0, 7'b0010011, 3'b011, 0, 0, 0, 0, 4'd6, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_XI, "EXECI"); cyc(0, T_WB, "ALUWB");

    start("sw_lat2", 1, 7'b0100011, 3'b010, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_FW, "F0"); cyc(0, T_FW, "F1"); cyc(0, T_F, "F2"); cyc(0, T_D, "D");
    cyc(0, T_MA, "MEMADR"); cyc(0, T_MWW, "MW0"); cyc(0, T_MWW, "MW1"); cyc(0, T_MW, "MW2");
    cyc(0, T_FW, "next_F0");

    start("lw", 0, 7'b0000011, 3'b010, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_MA, "MEMADR"); cyc(0, T_MR, "MEMREAD");
    cyc(0, T_MWB, "MEMWB"); cyc(0, T_F, "F2");

    start("lw_rst", 0, 7'b0000011, 3'b010, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_MA, "MEMADR"); cyc(1, T_RST, "rst_in_MEMREAD");
    cyc(0, T_F, "F_after"); cyc(0, T_D, "D_after");

    branch_test("bltu", 3'b110, 0, 1, 0, 0);
    branch_test("bge",  3'b101, 0, 1, 0, 0);
    branch_test("blt",  3'b100, 0, 1, 0, 1);
    branch_test("beq",  3'b000, 1, 0, 0, 1);
    branch_test("bne",  3'b001, 1, 0, 0, 0);
    branch_test("bgeu", 3'b111, 0, 0, 0, 1);
    branch_test("f3_010", 3'b010, 1, 1, 1, 0);

    start("jal", 0, 7'b1101111, 3'b000, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_JAL, "JAL"); cyc(0, T_WB, "ALUWB");

    start("jalr", 0, 7'b1100111, 3'b000, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_JALR, "JALR"); cyc(0, T_JAL, "JAL"); cyc(0, T_WB, "ALUWB");

    start("lui", 0, 7'b0110111, 3'b000, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_UP, "UPPER"); cyc(0, T_WB, "ALUWB");

    start("auipc", 0, 7'b0010111, 3'b000, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_UP, "UPPER"); cyc(0, T_WB, "ALUWB");

    start("illegal", 0, 7'b0000000, 3'b000, 0, 0, 0, 0, 4'd0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc(0, T_F, "F"); cyc(0, T_D, "D"); cyc(0, T_TRAP, "TRAP0"); cyc(0, T_TRAP, "TRAP1");
    @(negedge clk);
    #1;
    check_eq("illegal_o_held", {31'd0, d0_ill}, 32'd1);
    cyc(0, T_TRAP, "TRAP2");
    @(negedge clk);
    #1;
    check_eq("illegal_o_still", {31'd0, d0_ill}, 32'd1);
    start("illegal_exit", 0, 7'b0110011, 3'b000, 0, 0, 0, 0, 4'd0, 0);
    cyc(0, T_F, "F");
    @(negedge clk);
    #1;
    check_eq("illegal_o_cleared", {31'd0, d0_ill}, 32'd0);
`else
    cyc(0, T_F, "F"); cyc(0, T_DNOP, "D_nop"); cyc(0, T_F, "F2"); cyc(0, T_DNOP, "D_nop2");
`endif

    @(negedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Next-generation RISC-V control unit: FSM-sequenced multicycle controller for the shared-memory, single-ALU datapath.
- Replaces single-cycle combinational control.
- Supports memory wait states via parameter.
- Supports full RV32I branch set, JAL/JALR, LUI/AUIPC.
- Drives datapath mux selects and write strobes one state per cycle.

Parameters:
- MEM_LAT, 0, extra wait cycles per memory access (FETCH/MEMREAD/MEMWRITE occupy MEM_LAT+1 cycles).
- ALUCTRL_W, 4, ALUControl width (minimum 4).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- op  in  7  instruction opcode from IR
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU result == 0
- ALUR31  in  1  ALU result bit 31 (signed less-than after sub)
- branch_ltu  in  1  unsigned rs1 < rs2
- PCWrite  out  1  PC load strobe
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC load strobe
- RegWrite  out  1  register file write strobe
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U (decoded combinationally from op)
- ALUControl  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- instr_done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset: all logic on rising edge of clk.
  - While reset = 1: state <= FETCH, wait counter <= 0.
  - PCWrite, IRWrite, MemWrite, RegWrite, instr_done forced 0.
  - Other outputs at FETCH values.
  - Reset mid-instruction abandons it; no strobe fires on the reset cycle.
- Wait counter: in FETCH, MEMREAD and MEMWRITE, counts 0..MEM_LAT.
  - Strobes (PCWrite/IRWrite in FETCH, MemWrite in MEMWRITE) assert only on the final count.
  - State advances only on the final count; counter clears on state exit.
  - MEM_LAT = 0: no counter logic, single-cycle states.
- ALUOp (internal): 00 add, 01 sub, 10 funct decode via alu_decoder.
- States, outputs, transitions (unlisted outputs 0):
  - FETCH: AdrSrc = 0, IRWrite, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10, PCWrite -> DECODE.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch/JAL target into ALUOut).
    - lw/sw -> MEMADR
    - R -> EXECR
    - I-ALU -> EXECI
    - branch -> BRANCH
    - jal -> JAL
    - jalr -> JALR
    - lui/auipc -> UPPER
    - other -> ILLEGAL handling
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00; op[5] ? MEMWRITE : MEMREAD.
  - MEMREAD: AdrSrc = 1 -> MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite, instr_done -> FETCH.
  - MEMWRITE: AdrSrc = 1, MemWrite, instr_done -> FETCH.
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10 -> ALUWB.
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10 -> ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite, instr_done -> FETCH.
  - BRANCH: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, instr_done -> FETCH.
    - PCWrite = taken, decoded by funct3: beq Zero, bne !Zero, blt ALUR31, bge !ALUR31, bltu branch_ltu, bgeu !branch_ltu.
    - funct3 010/011: not taken.
  - JALR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00 -> JAL.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite -> ALUWB. Datapath clears bit 0 of target.
  - UPPER: ALUSrcA = op[5] ? 11 : 01, ALUSrcB = 01, ALUOp = 00 -> ALUWB.
- Latencies (MEM_LAT = 0):
  - R/I/U: 4 cycles
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4
  - jalr: 5
  - Each memory state adds MEM_LAT cycles.

Optional Feature:
- MC_ILLEGAL_TRAP_EN defined:
  - Unknown opcode -> TRAP state; adds output illegal_o (1 bit).
  - TRAP holds forever with illegal_o = 1 and all strobes 0; only reset exits.
- Undefined: unknown opcode treated as NOP: DECODE -> FETCH with instr_done pulse; no illegal_o port.

Decomposition:
- Package riscv_ctrl_pkg:
  - state enum
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ImmSrc, ResultSrc, ALUSrcA/B, ALUControl encodings
- Sub-module: existing alu_decoder instantiated unchanged (op[5], funct3, funct7b5, ALUOp).

Test Plan:
- add x3,x1,x2 (op 0110011, f7b5 = 0), MEM_LAT = 0 -> FETCH, DECODE, EXECR, ALUWB; ALUControl = 0 in EXECR; RegWrite = 1 only in cycle 4; instr_done in cycle 4.
- sw with MEM_LAT = 2 -> FETCH lasts 3 cycles, IRWrite/PCWrite only on 3rd; MEMWRITE 3 cycles, MemWrite only on 3rd; total 8 cycles.
- bltu, Zero = 0, ALUR31 = 1, branch_ltu = 0 -> BRANCH PCWrite = 0; bge same inputs -> PCWrite = 0; blt -> PCWrite = 1.
- jalr -> DECODE, JALR (ALUSrcA = 10, ALUSrcB = 01), JAL (PCWrite = 1, ResultSrc = 00), ALUWB (RegWrite = 1).
- lui -> UPPER ALUSrcA = 11, ImmSrc = 100; auipc -> ALUSrcA = 01.
- reset asserted in MEMREAD -> next cycle FETCH, no RegWrite; opcode 0000000 -> with MC_ILLEGAL_TRAP_EN illegal_o = 1 held; without, DECODE -> FETCH, instr_done = 1.
